// File: rtl/alu_ex_if.sv
// Execute-stage bus: issue side, ALU side and result side of alu_ex_sequencer.
interface alu_ex_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  // issue handshake and operands
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [XLEN-1:0] imm_i;
  logic            alusrc_i;
  logic [1:0]      aluop_i;
  logic [2:0]      funct3_i;
  logic            funct7b5_i;
  logic            branch_i;
  logic [4:0]      rd_i;
  // combinational ALU
  logic [XLEN-1:0] alu_in1_o;
  logic [XLEN-1:0] alu_in2_o;
  logic [3:0]      alu_ctrl_o;
  logic [XLEN-1:0] alu_res_i;
  logic            alu_zero_i;
  // result handshake
  logic             res_valid_o;
  logic             res_ready_i;
  logic [XLEN-1:0]  res_o;
  logic [4:0]       rd_o;
  logic             branch_taken_o;
  logic             illegal_o;
  logic [CNT_W-1:0] op_count_o;

  // environment side: upstream issue, the ALU and the writeback consumer
  modport master (
    output issue_valid_i, rs1_i, rs2_i, imm_i, alusrc_i, aluop_i, funct3_i,
           funct7b5_i, branch_i, rd_i, alu_res_i, alu_zero_i, res_ready_i,
    input  issue_ready_o, alu_in1_o, alu_in2_o, alu_ctrl_o, res_valid_o,
           res_o, rd_o, branch_taken_o, illegal_o, op_count_o
  );

  // sequencer side
  modport slave (
    input  issue_valid_i, rs1_i, rs2_i, imm_i, alusrc_i, aluop_i, funct3_i,
           funct7b5_i, branch_i, rd_i, alu_res_i, alu_zero_i, res_ready_i,
    output issue_ready_o, alu_in1_o, alu_in2_o, alu_ctrl_o, res_valid_o,
           res_o, rd_o, branch_taken_o, illegal_o, op_count_o
  );
endinterface

// File: rtl/alu_ex_sequencer.sv
// Execute-stage front end: decodes ALU control, drives the ALU from stage D,
// captures result/zero into stage E, resolves BEQ, counts retired results.
module alu_ex_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic     clk,
  input logic     rst,
  alu_ex_if.slave bus
);
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ILL = 4'b1111;

  logic [3:0]      dec_ctrl;
  logic            dec_ill;
  logic [XLEN-1:0] dec_in2;

  logic            d_valid;
  logic [XLEN-1:0] d_in1, d_in2;
  logic [3:0]      d_ctrl;
  logic            d_branch, d_ill;
  logic [4:0]      d_rd;

  logic e_free, accept;

  // ALU control decode from aluop/funct3/funct7b5; immediate forms never SUB
  always_comb begin
    dec_ctrl = C_ILL;
    dec_ill  = 1'b1;
    dec_in2  = bus.alusrc_i ? bus.imm_i : bus.rs2_i;
    case (bus.aluop_i)
      2'b00: begin dec_ctrl = C_ADD; dec_ill = 1'b0; end
      2'b01: begin dec_ctrl = C_SUB; dec_ill = 1'b0; end
      2'b10: begin
        case (bus.funct3_i)
          3'b000: begin
            dec_ctrl = (bus.funct7b5_i && !bus.alusrc_i) ? C_SUB : C_ADD;
            dec_ill  = 1'b0;
          end
          3'b111: begin dec_ctrl = C_AND; dec_ill = 1'b0; end
          3'b110: begin dec_ctrl = C_OR;  dec_ill = 1'b0; end
          default: begin dec_ctrl = C_ILL; dec_ill = 1'b1; end
        endcase
      end
      default: begin dec_ctrl = C_ILL; dec_ill = 1'b1; end
    endcase
  end

  assign e_free            = !bus.res_valid_o || bus.res_ready_i;
  assign bus.issue_ready_o = !d_valid || e_free;
  assign accept            = bus.issue_valid_i && bus.issue_ready_o;

  assign bus.alu_in1_o  = d_in1;
  assign bus.alu_in2_o  = d_in2;
  assign bus.alu_ctrl_o = d_ctrl;

  // Stage D: holds the op the ALU is currently evaluating
  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid  <= 1'b0;
      d_in1    <= '0;
      d_in2    <= '0;
      d_ctrl   <= '0;
      d_branch <= 1'b0;
      d_ill    <= 1'b0;
      d_rd     <= '0;
    end else if (accept) begin
      d_valid  <= 1'b1;
      d_in1    <= bus.rs1_i;
      d_in2    <= dec_in2;
      d_ctrl   <= dec_ctrl;
      d_branch <= bus.branch_i;
      d_ill    <= dec_ill;
      d_rd     <= bus.rd_i;
    end else if (e_free) begin
      d_valid  <= 1'b0;
    end
  end

  // Stage E: registered result; holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid_o    <= 1'b0;
      bus.res_o          <= '0;
      bus.rd_o           <= '0;
      bus.branch_taken_o <= 1'b0;
      bus.illegal_o      <= 1'b0;
    end else if (d_valid && e_free) begin
      bus.res_valid_o    <= 1'b1;
      bus.res_o          <= d_ill ? '0 : bus.alu_res_i;
      bus.rd_o           <= d_rd;
      bus.branch_taken_o <= d_branch && bus.alu_zero_i && !d_ill;
      bus.illegal_o      <= d_ill;
    end else if (bus.res_ready_i) begin
      bus.res_valid_o    <= 1'b0;
    end
  end

  // Retired-op counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)
      bus.op_count_o <= '0;
    else if (bus.res_valid_o && bus.res_ready_i)
      bus.op_count_o <= bus.op_count_o + 1'b1;
  end
endmodule
